// File: rtl/sqrt_request_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter in front of the binary-search sqrt engine.
package sqrt_request_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam int         OPW      = 8;
  localparam logic [7:0] ROOT_SAT = 8'hFF;

  function automatic logic [7:0] idx_to_onehot(input logic [2:0] idx);
    return 8'd1 << idx;
  endfunction

endpackage

// File: rtl/sqrt_request_arbiter_rr_priority_picker.sv
// Round-robin picker: first asserted request at or above i_ptr, wrapping past the top lane.
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_grant,
  output logic               o_any_valid
);

  logic [IDX_W-1:0] w_idx;

  // Scan from the farthest offset down so the lane nearest the pointer is written last and wins.
  always_comb begin
    o_grant     = '0;
    o_any_valid = 1'b0;
    w_idx       = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      w_idx       = IDX_W'((int'(i_ptr) + off) % NUM_REQ);
      o_grant     = i_req[w_idx] ? w_idx : o_grant;
      o_any_valid = o_any_valid | i_req[w_idx];
    end
  end

endmodule

// File: rtl/sqrt_request_arbiter.sv
// Shares one sqrt engine among NUM_REQ lanes: round-robin grant, one operation in flight,
// result returned to the granted lane with a one-cycle pulse; engine hangs become timeouts.
module sqrt_request_arbiter
  import sqrt_request_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int IDX_W       = 2,
  parameter int TIMEOUT_CYC = 40
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  input  logic [OPW*NUM_REQ-1:0] i_req_x,
  input  logic [OPW*NUM_REQ-1:0] i_req_y,
  output logic [NUM_REQ-1:0]     o_req_ack,
  output logic [NUM_REQ-1:0]     o_resp_valid,
  output logic [OPW-1:0]         o_resp_root,
  output logic                   o_resp_err,
  output logic                   o_fault,
  output logic                   o_busy,
  output logic                   o_sq_start,
  output logic [OPW-1:0]         o_sq_x,
  output logic [OPW-1:0]         o_sq_y,
  input  logic                   i_sq_ready,
  input  logic [OPW-1:0]         i_sq_root
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC);

  arb_state_e         r_state;
  arb_state_e         w_state_nxt;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_grant;
  logic [TMR_W-1:0]   r_timer;
  logic [NUM_REQ-1:0] r_req_ack;
  logic [NUM_REQ-1:0] r_resp_valid;
  logic [OPW-1:0]     r_resp_root;
  logic               r_resp_err;
  logic               r_fault;
  logic               r_busy;
  logic               r_sq_start;
  logic [OPW-1:0]     r_sq_x;
  logic [OPW-1:0]     r_sq_y;

  logic [IDX_W-1:0]   w_pick;
  logic               w_any_valid;
  logic [NUM_REQ-1:0] w_pick_oh;
  logic [NUM_REQ-1:0] w_grant_oh;
  logic [OPW-1:0]     w_sel_x;
  logic [OPW-1:0]     w_sel_y;
  logic               w_ready_ok;
  logic               w_timeout;
  logic [NUM_REQ-1:0] w_ack_nxt;
  logic [NUM_REQ-1:0] w_resp_valid_nxt;
  logic               w_start_nxt;
  logic               w_capture_op;
  logic               w_load_root;
  logic               w_load_sat;
  logic               w_advance_ptr;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_req       (i_req_valid),
    .i_ptr       (r_rr_ptr),
    .o_grant     (w_pick),
    .o_any_valid (w_any_valid)
  );

  assign w_pick_oh  = NUM_REQ'(idx_to_onehot(3'(w_pick)));
  assign w_grant_oh = NUM_REQ'(idx_to_onehot(3'(r_grant)));
  assign w_sel_x    = i_req_x[int'(w_pick) * OPW +: OPW];
  assign w_sel_y    = i_req_y[int'(w_pick) * OPW +: OPW];

  // The first WAIT cycle still sees the engine's ready level from the previous operation.
  assign w_ready_ok = (r_timer != '0) && i_sq_ready;
  assign w_timeout  = (r_timer == TMR_W'(TIMEOUT_CYC - 1)) && !w_ready_ok;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  w_state_nxt = w_any_valid ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT:  w_state_nxt = (w_ready_ok || w_timeout) ? ST_RESP : ST_WAIT;
      ST_RESP:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: values the output registers take at the next edge
  always_comb begin
    w_ack_nxt        = '0;
    w_resp_valid_nxt = '0;
    w_start_nxt      = 1'b0;
    w_capture_op     = 1'b0;
    w_load_root      = 1'b0;
    w_load_sat       = 1'b0;
    w_advance_ptr    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ack_nxt    = w_any_valid ? w_pick_oh : '0;
        w_capture_op = w_any_valid;
      end
      ST_ISSUE: w_start_nxt = 1'b1;
      ST_WAIT: begin
        w_resp_valid_nxt = (w_ready_ok || w_timeout) ? w_grant_oh : '0;
        w_load_root      = w_ready_ok;
        w_load_sat       = w_timeout;
      end
      ST_RESP:  w_advance_ptr = 1'b1;
      default:  w_advance_ptr = 1'b0;
    endcase
  end

  // Pulse outputs, grant capture, operand hold and round-robin pointer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req_ack    <= '0;
      r_resp_valid <= '0;
      r_sq_start   <= 1'b0;
      r_busy       <= 1'b0;
      r_grant      <= '0;
      r_sq_x       <= '0;
      r_sq_y       <= '0;
      r_rr_ptr     <= '0;
    end else begin
      r_req_ack    <= w_ack_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_sq_start   <= w_start_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
      if (w_capture_op) begin
        r_grant <= w_pick;
        r_sq_x  <= w_sel_x;
        r_sq_y  <= w_sel_y;
      end
      if (w_advance_ptr) begin
        r_rr_ptr <= (r_grant == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant + IDX_W'(1);
      end
    end
  end

  // WAIT-cycle counter, cleared while the start pulse is being issued
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_timer <= '0;
    end else if (r_state == ST_ISSUE) begin
      r_timer <= '0;
    end else if (r_state == ST_WAIT) begin
      r_timer <= r_timer + TMR_W'(1);
    end
  end

  // Result registers hold until the next response; fault is sticky until reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_resp_root <= '0;
      r_resp_err  <= 1'b0;
      r_fault     <= 1'b0;
    end else if (w_load_root) begin
      r_resp_root <= i_sq_root;
      r_resp_err  <= 1'b0;
    end else if (w_load_sat) begin
      r_resp_root <= ROOT_SAT;
      r_resp_err  <= 1'b1;
      r_fault     <= 1'b1;
    end
  end

  assign o_req_ack    = r_req_ack;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_root  = r_resp_root;
  assign o_resp_err   = r_resp_err;
  assign o_fault      = r_fault;
  assign o_busy       = r_busy;
  assign o_sq_start   = r_sq_start;
  assign o_sq_x       = r_sq_x;
  assign o_sq_y       = r_sq_y;

endmodule
